alu_exec_unit: RTL and testbench
================================

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width in bits (legal values 32, 64).
REQ-002 SHALL have parameter DIV_BITS_PER_CYCLE, default 1, quotient bits resolved per divider cycle (1 or 2; XLEN divisible by it).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports in_valid input 1 and in_ready output 1, the request handshake.
REQ-006 SHALL have ports opcode input 7, funct3 input 3 and funct7 input 7, the instruction fields.
REQ-007 SHALL have ports src_a input XLEN and src_b input XLEN, the operands (src_b already holds the immediate for OP-IMM).
REQ-008 SHALL have ports out_valid output 1 and out_ready input 1, the response handshake.
REQ-009 SHALL have ports result output XLEN, zero output 1 (result==0) and illegal output 1 (unsupported encoding).

Function
REQ-010 SHALL use FSM states IDLE, EXEC, DIV, DONE.
REQ-011 SHALL have in_ready=1 only in IDLE, and SHALL accept a request on in_valid&in_ready, registering all inputs.
REQ-012 SHALL transition IDLE->EXEC on accept.
REQ-013 SHALL, in EXEC, go EXEC->DIV for divide/remainder ops and EXEC->DONE for all other ops, loading result/zero/illegal.
REQ-014 SHALL have a latency from accept to out_valid of 2 cycles for non-divide ops.
REQ-015 SHALL hold result/zero/illegal stable in DONE with out_valid=1 until out_ready, then go DONE->IDLE.
REQ-016 SHALL decode OP (0110011) funct7=0000000 as add, sll, slt, sltu, xor, srl, or, and by funct3, and funct7=0100000 as sub (funct3 000) and sra (funct3 101).
REQ-017 SHALL decode OP-IMM (0010011) as addi, slti, sltiu, xori, ori, andi with funct7 ignored, slli with funct7=0000000, and srli/srai with funct7=0000000/0100000.
REQ-018 SHALL take the shift amount from src_b[$clog2(XLEN)-1:0].
REQ-019 SHALL produce slt/sltu as a zero-extended 0/1; all arithmetic SHALL be modulo 2^XLEN.
REQ-020 SHALL treat any other opcode or funct7 combination as illegal: result=0, illegal=1, EXEC->DONE.

Reset
REQ-021 SHALL, on reset (including mid-DIV or while in DONE), go to IDLE with result=0, zero=0, illegal=0, out_valid=0, in_ready=0 during the reset cycle and 1 on the cycle after, with any in-flight operation discarded.

Configuration
REQ-022 SHALL, with RV_M_EXT_EN defined, decode OP with funct7=0000001 by funct3 as mul, mulh, mulhsu, mulhu (resolved in EXEC, latency 2), div, divu, rem, remu (iterative DIV).
REQ-023 SHALL take exactly XLEN/DIV_BITS_PER_CYCLE cycles in DIV, then go DIV->DONE.
REQ-024 SHALL return all-ones quotient and remainder=src_a for divide by zero, and quotient=src_a, remainder=0 for signed overflow (-2^(XLEN-1)/-1).
REQ-025 SHALL, without RV_M_EXT_EN, treat funct7=0000001 as illegal, never enter DIV, and synthesise no multiplier or divider logic.

Structure
REQ-026 SHALL put opcode constants, the funct7 constants, the internal ALU-op enum and the FSM state typedef in shared package alu_pkg.
REQ-027 SHALL implement the iterative restoring divider as sub-module div_iter (start/busy/done, signed/unsigned), instantiated only under RV_M_EXT_EN.

Verification
REQ-028 SHALL cover: XLEN=32, addi src_a=5, src_b=0xFFFFFFFD -> result=2, zero=0, out_valid 2 cycles after accept.
REQ-029 SHALL cover: sra src_a=0x80000000, src_b=4 -> 0xF8000000; srl same operands -> 0x08000000; sub 7-7 -> 0, zero=1.
REQ-030 SHALL cover: out_ready held low 5 cycles in DONE -> result stable, in_ready=0 throughout; accepted on the 6th cycle, IDLE on the next.
REQ-031 SHALL cover: opcode 0110111, or OP with funct7=0100000 and funct3=110 -> illegal=1, result=0.
REQ-032 SHALL cover, with RV_M_EXT_EN: divu 100/0 -> 0xFFFFFFFF; rem 0x80000000%-1 -> 0; div 0x80000000/-1 -> 0x80000000; div -7/2 -> -3 after 32 DIV cycles.
REQ-033 SHALL cover: reset asserted on the 10th DIV cycle -> out_valid=0 and in_ready=1 on the cycle after reset, then a new add completes correctly.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode/funct7 constants, ALU-op and FSM enums, and the instruction decoder
// used by alu_exec_unit and its divider.
package alu_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

    typedef enum logic [1:0] {IDLE, EXEC, DIV, DONE} state_e;

    typedef enum logic [4:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
        ALU_OR, ALU_AND, ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
        ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU, ALU_ILLEGAL
    } alu_op_e;

    typedef struct packed {
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic [6:0] funct7;
    } insn_t;

    // m_en gates the funct7=0000001 group; when clear those encodings are illegal.
    function automatic alu_op_e decode_op(input logic [6:0] opcode, input logic [2:0] f3,
                                          input logic [6:0] f7, input logic m_en);
        alu_op_e op;
        op = ALU_ILLEGAL;
        if (opcode == OPC_OP_IMM) begin
            case (f3)
                3'b000:  op = ALU_ADD;
                3'b001:  op = (f7 == F7_BASE) ? ALU_SLL : ALU_ILLEGAL;
                3'b010:  op = ALU_SLT;
                3'b011:  op = ALU_SLTU;
                3'b100:  op = ALU_XOR;
                3'b101:  op = (f7 == F7_BASE) ? ALU_SRL : ((f7 == F7_ALT) ? ALU_SRA : ALU_ILLEGAL);
                3'b110:  op = ALU_OR;
                default: op = ALU_AND;
            endcase
        end else if (opcode == OPC_OP) begin
            if (f7 == F7_BASE) begin
                case (f3)
                    3'b000:  op = ALU_ADD;
                    3'b001:  op = ALU_SLL;
                    3'b010:  op = ALU_SLT;
                    3'b011:  op = ALU_SLTU;
                    3'b100:  op = ALU_XOR;
                    3'b101:  op = ALU_SRL;
                    3'b110:  op = ALU_OR;
                    default: op = ALU_AND;
                endcase
            end else if (f7 == F7_ALT) begin
                if (f3 == 3'b000)      op = ALU_SUB;
                else if (f3 == 3'b101) op = ALU_SRA;
            end else if (f7 == F7_MULDIV && m_en) begin
                case (f3)
                    3'b000:  op = ALU_MUL;
                    3'b001:  op = ALU_MULH;
                    3'b010:  op = ALU_MULHSU;
                    3'b011:  op = ALU_MULHU;
                    3'b100:  op = ALU_DIV;
                    3'b101:  op = ALU_DIVU;
                    3'b110:  op = ALU_REM;
                    default: op = ALU_REMU;
                endcase
            end
        end
        return op;
    endfunction

    function automatic logic is_div_op(input alu_op_e op);
        return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
    endfunction

endpackage

// File: rtl/div_iter.sv
// div_iter: iterative restoring divider resolving BITS_PER_CYCLE quotient bits per cycle.
// Divides magnitudes and fixes signs afterwards; divide-by-zero yields all-ones / dividend.
module div_iter
    import alu_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            is_signed,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);
    localparam int STEPS = XLEN / BITS_PER_CYCLE;
    localparam int CW    = $clog2(STEPS);
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    logic            busy_q, busy_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, a_q, a_d;
    logic            qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;

    logic [XLEN-1:0] rem_s, quo_s, abs_a, abs_b;
    logic [XLEN:0]   rem_sh, diff;

    assign abs_a = (is_signed & dividend[XLEN-1]) ? -dividend : dividend;
    assign abs_b = (is_signed & divisor[XLEN-1])  ? -divisor  : divisor;

    // One restoring step per quotient bit; the quotient register doubles as the dividend shifter.
    always_comb begin
        rem_s  = rem_q;
        quo_s  = quo_q;
        rem_sh = '0;
        diff   = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            rem_sh = {rem_s, quo_s[XLEN-1]};
            diff   = rem_sh - {1'b0, dvs_q};
            quo_s  = {quo_s[XLEN-2:0], ~diff[XLEN]};
            rem_s  = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
        end
    end

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        a_d    = a_q;
        qneg_d = qneg_q;
        rneg_d = rneg_q;
        dz_d   = dz_q;
        if (start) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            rem_d  = '0;
            quo_d  = abs_a;
            dvs_d  = abs_b;
            a_d    = dividend;
            qneg_d = is_signed & (dividend[XLEN-1] ^ divisor[XLEN-1]);
            rneg_d = is_signed & dividend[XLEN-1];
            dz_d   = (divisor == '0);
        end else if (busy_q) begin
            rem_d  = rem_s;
            quo_d  = quo_s;
            cnt_d  = cnt_q + CW'(1);
            busy_d = (cnt_q != LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            a_q    <= '0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
            dz_q   <= 1'b0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            a_q    <= a_d;
            qneg_q <= qneg_d;
            rneg_q <= rneg_d;
            dz_q   <= dz_d;
        end
    end

    // Results are taken from the final step combinationally so the caller can leave DIV on done.
    assign busy      = busy_q;
    assign done      = busy_q && (cnt_q == LAST);
    assign quotient  = dz_q ? '1  : (qneg_q ? -quo_s : quo_s);
    assign remainder = dz_q ? a_q : (rneg_q ? -rem_s : rem_s);

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: RV32I/RV64I integer ALU behind a valid/ready request/response handshake.
// Define RV_M_EXT_EN to add multiply (resolved in EXEC) and the iterative divider (DIV state).
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int XLEN               = 32,
    parameter int DIV_BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);
    localparam int SHW = $clog2(XLEN);
`ifdef RV_M_EXT_EN
    localparam logic M_EN = 1'b1;
`else
    localparam logic M_EN = 1'b0;
`endif

    if ((XLEN != 32 && XLEN != 64) || (DIV_BITS_PER_CYCLE != 1 && DIV_BITS_PER_CYCLE != 2)) begin : g_bad_cfg
        $error("alu_exec_unit: unsupported XLEN / DIV_BITS_PER_CYCLE");
    end

    state_e          state_q, state_d;
    insn_t           insn_q, insn_d;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
    logic            zero_q, zero_d, illegal_q, illegal_d;

    alu_op_e         op;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] alu_res;
    logic            exec_div;

    assign op    = decode_op(insn_q.opcode, insn_q.funct3, insn_q.funct7, M_EN);
    assign shamt = b_q[SHW-1:0];

`ifdef RV_M_EXT_EN
    logic                mul_a_sgn, mul_b_sgn;
    logic [2*XLEN-1:0]   mul_prod;
    logic                div_start, div_busy, div_done;
    logic [XLEN-1:0]     div_quo, div_rem, div_res;

    // Sign-extending to 2*XLEN makes one unsigned multiplier cover mulh/mulhsu/mulhu.
    assign mul_a_sgn = ((op == ALU_MULH) || (op == ALU_MULHSU)) & a_q[XLEN-1];
    assign mul_b_sgn = (op == ALU_MULH) & b_q[XLEN-1];
    assign mul_prod  = {{XLEN{mul_a_sgn}}, a_q} * {{XLEN{mul_b_sgn}}, b_q};

    assign exec_div  = is_div_op(op);
    assign div_start = (state_q == EXEC) && exec_div;
    assign div_res   = insn_q.funct3[1] ? div_rem : div_quo;

    div_iter #(
        .XLEN           (XLEN),
        .BITS_PER_CYCLE (DIV_BITS_PER_CYCLE)
    ) u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start),
        .is_signed (~insn_q.funct3[0]),
        .dividend  (a_q),
        .divisor   (b_q),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );
`else
    assign exec_div = 1'b0;
`endif

    always_comb begin
        alu_res = '0;
        case (op)
            ALU_ADD:    alu_res = a_q + b_q;
            ALU_SUB:    alu_res = a_q - b_q;
            ALU_SLL:    alu_res = a_q << shamt;
            ALU_SLT:    alu_res = {{(XLEN-1){1'b0}}, $signed(a_q) < $signed(b_q)};
            ALU_SLTU:   alu_res = {{(XLEN-1){1'b0}}, a_q < b_q};
            ALU_XOR:    alu_res = a_q ^ b_q;
            ALU_SRL:    alu_res = a_q >> shamt;
            ALU_SRA:    alu_res = $unsigned($signed(a_q) >>> shamt);
            ALU_OR:     alu_res = a_q | b_q;
            ALU_AND:    alu_res = a_q & b_q;
`ifdef RV_M_EXT_EN
            ALU_MUL:    alu_res = mul_prod[XLEN-1:0];
            ALU_MULH,
            ALU_MULHSU,
            ALU_MULHU:  alu_res = mul_prod[2*XLEN-1:XLEN];
`endif
            default:    alu_res = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        insn_d    = insn_q;
        a_d       = a_q;
        b_d       = b_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    insn_d  = '{opcode: opcode, funct3: funct3, funct7: funct7};
                    a_d     = src_a;
                    b_d     = src_b;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (exec_div) begin
                    state_d = DIV;
                end else begin
                    result_d  = alu_res;
                    zero_d    = (alu_res == '0);
                    illegal_d = (op == ALU_ILLEGAL);
                    state_d   = DONE;
                end
            end
`ifdef RV_M_EXT_EN
            DIV: begin
                if (div_busy && div_done) begin
                    result_d  = div_res;
                    zero_d    = (div_res == '0);
                    illegal_d = 1'b0;
                    state_d   = DONE;
                end
            end
`endif
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            insn_q    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            insn_q    <= insn_d;
            a_q       <= a_d;
            b_q       <= b_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

    // Handshake outputs are masked during the reset cycle itself, whatever the state was.
    assign in_ready  = (state_q == IDLE) && !reset;
    assign out_valid = (state_q == DONE) && !reset;
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomized self-checking bench for alu_exec_unit (XLEN=32) against a behavioural model;
// M-extension cases are exercised when RV_M_EXT_EN is defined.
module tb_alu_exec_unit;
    localparam int NDIV = 32;
    localparam logic [6:0] OP  = 7'b0110011;
    localparam logic [6:0] OPI = 7'b0010011;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, out_valid, out_ready, zero, illegal;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [31:0] src_a, src_b, result;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] res;
        logic        ill;
        logic        isdiv;
    } exp_t;
    exp_t exp_q[$];

    alu_exec_unit #(.XLEN(32), .DIV_BITS_PER_CYCLE(1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .funct7(funct7), .src_a(src_a), .src_b(src_b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero), .illegal(illegal)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endfunction

    // Reference: straight from the instruction-set rules, 32-bit.
    function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int sa, sb;
        int unsigned sh;
        longint pa;
        longint unsigned pu;
        e.res = 32'h0; e.ill = 1'b0; e.isdiv = 1'b0;
        sa = a; sb = b; sh = 32'(b[4:0]);
        pa = 0; pu = 0;
        if (op == OPI) begin
            case (f3)
                3'd0: e.res = a + b;
                3'd1: if (f7 == 7'h00) e.res = a << sh; else e.ill = 1'b1;
                3'd2: e.res = 32'(sa < sb);
                3'd3: e.res = 32'(a < b);
                3'd4: e.res = a ^ b;
                3'd5: if (f7 == 7'h00) e.res = a >> sh;
                      else if (f7 == 7'h20) e.res = sa >>> sh;
                      else e.ill = 1'b1;
                3'd6: e.res = a | b;
                default: e.res = a & b;
            endcase
        end else if (op == OP && f7 == 7'h00) begin
            case (f3)
                3'd0: e.res = a + b;
                3'd1: e.res = a << sh;
                3'd2: e.res = 32'(sa < sb);
                3'd3: e.res = 32'(a < b);
                3'd4: e.res = a ^ b;
                3'd5: e.res = a >> sh;
                3'd6: e.res = a | b;
                default: e.res = a & b;
            endcase
        end else if (op == OP && f7 == 7'h20 && f3 == 3'd0) begin
            e.res = a - b;
        end else if (op == OP && f7 == 7'h20 && f3 == 3'd5) begin
            e.res = sa >>> sh;
        end else if (op == OP && f7 == 7'h01) begin
`ifdef RV_M_EXT_EN
            case (f3)
                3'd0: e.res = a * b;
                3'd1: begin pa = longint'(sa) * longint'(sb); e.res = pa[63:32]; end
                3'd2: begin pa = longint'(sa) * longint'({32'h0, b}); e.res = pa[63:32]; end
                3'd3: begin pu = {32'h0, a} * {32'h0, b}; e.res = pu[63:32]; end
                3'd4: e.res = (b == 0) ? 32'hFFFFFFFF : ((a == 32'h80000000 && b == 32'hFFFFFFFF) ? a : 32'(sa / sb));
                3'd5: e.res = (b == 0) ? 32'hFFFFFFFF : a / b;
                3'd6: e.res = (b == 0) ? a : ((a == 32'h80000000 && b == 32'hFFFFFFFF) ? 32'h0 : 32'(sa % sb));
                default: e.res = (b == 0) ? a : a % b;
            endcase
            e.isdiv = f3[2];
`else
            e.ill = 1'b1;
`endif
        end else begin
            e.ill = 1'b1;
        end
        return e;
    endfunction

    // Compare process: every cycle the response is valid it must match the oldest expectation.
    initial begin : compare
        forever begin
            @(posedge clk); #1;
            if (!reset && out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious out_valid", 32'(out_valid), 32'h0);
                end else begin
                    chk("model result", result, exp_q[0].res);
                    chk("model zero", 32'(zero), 32'(exp_q[0].res == 32'h0));
                    chk("model illegal", 32'(illegal), 32'(exp_q[0].ill));
                end
            end
            @(negedge clk); #1;
            if (!reset && out_valid && out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
        end
    end

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        chk({tag, " in_ready in reset"}, 32'(in_ready), 32'h0);
        chk({tag, " out_valid in reset"}, 32'(out_valid), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        #1;
        chk({tag, " in_ready after reset"}, 32'(in_ready), 32'h1);
        chk({tag, " out_valid after reset"}, 32'(out_valid), 32'h0);
        chk({tag, " result after reset"}, result, 32'h0);
        chk({tag, " flags after reset"}, {30'h0, zero, illegal}, 32'h0);
    endtask

    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b, input string tag);
        @(negedge clk);
        chk({tag, " in_ready idle"}, 32'(in_ready), 32'h1);
        opcode = op; funct3 = f3; funct7 = f7; src_a = a; src_b = b;
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        exp_q.push_back(model(op, f3, f7, a, b));
        @(negedge clk);
        in_valid = 1'b0;
        src_a = $urandom; src_b = $urandom;
    endtask

    task automatic run_op(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [31:0] a, input logic [31:0] b, input int hold,
                          input logic lit, input logic [31:0] lit_res, input logic lit_ill,
                          input string tag);
        exp_t e;
        int lat;
        logic [31:0] first;
        e = model(op, f3, f7, a, b);
        issue(op, f3, f7, a, b, tag);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) begin
            chk({tag, " response timeout"}, 32'(out_valid), 32'h1);
            do_reset("recover");
            return;
        end
        chk({tag, " latency"}, 32'(lat), e.isdiv ? 32'(NDIV + 2) : 32'd2);
        if (lit) begin
            chk({tag, " result"}, result, lit_res);
            chk({tag, " zero"}, 32'(zero), 32'(lit_res == 32'h0));
            chk({tag, " illegal"}, 32'(illegal), 32'(lit_ill));
        end
        first = result;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, " held out_valid"}, 32'(out_valid), 32'h1);
            chk({tag, " held in_ready"}, 32'(in_ready), 32'h0);
            chk({tag, " held result"}, result, first);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, " out_valid after handshake"}, 32'(out_valid), 32'h0);
        chk({tag, " in_ready after handshake"}, 32'(in_ready), 32'h1);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [6:0] op, f7;
        logic [2:0] f3;
        logic [31:0] a, b;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        opcode = 7'h0; funct3 = 3'h0; funct7 = 7'h0; src_a = 32'h0; src_b = 32'h0;
        do_reset("por");

        run_op(OPI, 3'd0, 7'h00, 32'd5, 32'hFFFFFFFD, 0, 1'b1, 32'd2, 1'b0, "addi");
        run_op(OP, 3'd5, 7'h20, 32'h80000000, 32'd4, 0, 1'b1, 32'hF8000000, 1'b0, "sra");
        run_op(OP, 3'd5, 7'h00, 32'h80000000, 32'd4, 0, 1'b1, 32'h08000000, 1'b0, "srl");
        run_op(OP, 3'd0, 7'h20, 32'd7, 32'd7, 1, 1'b1, 32'h0, 1'b0, "sub");
        run_op(OPI, 3'd3, 7'h55, 32'd3, 32'hFFFFFFFF, 0, 1'b1, 32'd1, 1'b0, "sltiu");
        run_op(OP, 3'd2, 7'h00, 32'hFFFFFFFF, 32'd0, 0, 1'b1, 32'd1, 1'b0, "slt");
        run_op(OPI, 3'd1, 7'h00, 32'h00000001, 32'd31, 0, 1'b1, 32'h80000000, 1'b0, "slli");
        run_op(OP, 3'd0, 7'h00, 32'd3, 32'd4, 5, 1'b1, 32'd7, 1'b0, "add hold");
        run_op(7'b0110111, 3'd0, 7'h00, 32'd1, 32'd2, 0, 1'b1, 32'h0, 1'b1, "lui illegal");
        run_op(OP, 3'd6, 7'h20, 32'hFF, 32'h0F, 0, 1'b1, 32'h0, 1'b1, "or alt illegal");
        run_op(OPI, 3'd5, 7'h10, 32'hFF, 32'd1, 0, 1'b1, 32'h0, 1'b1, "srxi illegal");
`ifdef RV_M_EXT_EN
        run_op(OP, 3'd5, 7'h01, 32'd100, 32'd0, 0, 1'b1, 32'hFFFFFFFF, 1'b0, "divu by 0");
        run_op(OP, 3'd6, 7'h01, 32'h80000000, 32'hFFFFFFFF, 0, 1'b1, 32'h0, 1'b0, "rem ovf");
        run_op(OP, 3'd4, 7'h01, 32'h80000000, 32'hFFFFFFFF, 0, 1'b1, 32'h80000000, 1'b0, "div ovf");
        run_op(OP, 3'd4, 7'h01, 32'hFFFFFFF9, 32'd2, 0, 1'b1, 32'hFFFFFFFD, 1'b0, "div -7/2");
        run_op(OP, 3'd1, 7'h01, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b1, 32'h0, 1'b0, "mulh -1*-1");
        issue(OP, 3'd4, 7'h01, 32'd1000, 32'd7, "div reset");
        repeat (9) @(posedge clk);
        do_reset("mid-div");
`else
        run_op(OP, 3'd0, 7'h01, 32'd3, 32'd4, 0, 1'b1, 32'h0, 1'b1, "mul disabled");
        run_op(OP, 3'd4, 7'h01, 32'd8, 32'd2, 0, 1'b1, 32'h0, 1'b1, "div disabled");
        issue(OP, 3'd0, 7'h00, 32'd1, 32'd1, "done reset");
        @(posedge clk); #1;
        chk("done reset out_valid", 32'(out_valid), 32'h1);
        do_reset("mid-done");
`endif
        run_op(OP, 3'd0, 7'h00, 32'h12345678, 32'h11111111, 0, 1'b1, 32'h23456789, 1'b0, "add post reset");

        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: op = OP;
                4, 5, 6, 7: op = OPI;
                default:    op = 7'($urandom);
            endcase
            case ($urandom_range(0, 3))
                0: f7 = 7'h00;
                1: f7 = 7'h20;
                2: f7 = 7'h01;
                default: f7 = 7'($urandom);
            endcase
            f3 = 3'($urandom);
            case ($urandom_range(0, 5))
                0: a = 32'h0;
                1: a = 32'h80000000;
                2: a = 32'hFFFFFFFF;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: b = 32'h0;
                1: b = 32'hFFFFFFFF;
                2: b = 32'($urandom_range(0, 40));
                default: b = $urandom;
            endcase
            run_op(op, f3, f7, a, b, $urandom_range(0, 2), 1'b0, 32'h0, 1'b0, "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
